// File: rtl/riscv_pkg.sv
// Shared RV32I opcode constants, hazard-controller state encoding and operand-use decode.
package riscv_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_HALT  = 2'd3
    } hz_state_t;

    function automatic logic rs1_used(input logic [6:0] opc);
        return !((opc == OPC_LUI) || (opc == OPC_AUIPC) || (opc == OPC_JAL));
    endfunction

    function automatic logic rs2_used(input logic [6:0] opc);
        return (opc == OPC_OP) || (opc == OPC_STORE) || (opc == OPC_BRANCH);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; synchronous active-high reset.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] q
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign q = cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: boot hold, load-use stall, taken-branch flush,
// debug halt/drain handshake, plus saturating stall/flush event counters.
module hazard_ctrl
    import riscv_pkg::*;
#(
    parameter int unsigned BOOT_CYCLES  = 2,
    parameter int unsigned DRAIN_CYCLES = 3,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       OPCODE_ID,
    input  logic [4:0]       RS1_ID,
    input  logic [4:0]       RS2_ID,
    input  logic             MemRead_EX,
    input  logic [4:0]       RD_EX,
    input  logic             PCSrc_EX,
    input  logic             halt_req,
    output logic             PC_write,
    output logic             IF_ID_write,
    output logic             IF_ID_flush,
    output logic             control_sel,
    output logic             halt_ack,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int unsigned BOOT_W  = (BOOT_CYCLES  > 1) ? $clog2(BOOT_CYCLES)  : 1;
    localparam int unsigned DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    // With no boot hold the controller comes out of reset already running.
    localparam hz_state_t RESET_ST = (BOOT_CYCLES == 0) ? ST_RUN : ST_BOOT;

    hz_state_t          state_q, state_d;
    logic [BOOT_W-1:0]  boot_cnt_q, boot_cnt_d;
    logic [DRAIN_W-1:0] drain_cnt_q, drain_cnt_d;
    logic               luh;
    logic               stall_inc;
    logic               flush_inc;

    always_comb begin
        luh = MemRead_EX && (RD_EX != 5'd0) &&
              (((RD_EX == RS1_ID) && rs1_used(OPCODE_ID)) ||
               ((RD_EX == RS2_ID) && rs2_used(OPCODE_ID)));
    end

    // Next state and combinational outputs; the stall pattern is the common case outside RUN.
    always_comb begin
        state_d     = state_q;
        boot_cnt_d  = boot_cnt_q;
        drain_cnt_d = drain_cnt_q;
        PC_write    = 1'b0;
        IF_ID_write = 1'b0;
        IF_ID_flush = 1'b0;
        control_sel = 1'b1;
        halt_ack    = 1'b0;
        stall_inc   = 1'b0;
        flush_inc   = 1'b0;

        if (reset) begin
            IF_ID_flush = 1'b1;
        end else begin
            case (state_q)
                ST_BOOT: begin
                    IF_ID_flush = 1'b1;
                    if (boot_cnt_q == BOOT_W'(BOOT_CYCLES - 1)) begin
                        state_d    = ST_RUN;
                        boot_cnt_d = '0;
                    end else begin
                        boot_cnt_d = boot_cnt_q + BOOT_W'(1);
                    end
                end
                ST_RUN: begin
                    if (PCSrc_EX) begin
                        PC_write    = 1'b1;
                        IF_ID_write = 1'b1;
                        IF_ID_flush = 1'b1;
                        flush_inc   = 1'b1;
                    end else if (luh) begin
                        stall_inc = 1'b1;
                    end else if (halt_req) begin
                        state_d     = ST_DRAIN;
                        drain_cnt_d = '0;
                    end else begin
                        PC_write    = 1'b1;
                        IF_ID_write = 1'b1;
                        control_sel = 1'b0;
                    end
                end
                ST_DRAIN: begin
                    // A flush here is a protocol error: honour it but freeze the drain.
                    if (PCSrc_EX) begin
                        PC_write    = 1'b1;
                        IF_ID_write = 1'b1;
                        IF_ID_flush = 1'b1;
                        flush_inc   = 1'b1;
                    end else if (!halt_req) begin
                        state_d     = ST_RUN;
                        drain_cnt_d = '0;
                    end else if (drain_cnt_q == DRAIN_W'(DRAIN_CYCLES - 1)) begin
                        state_d     = ST_HALT;
                        drain_cnt_d = '0;
                    end else begin
                        drain_cnt_d = drain_cnt_q + DRAIN_W'(1);
                    end
                end
                ST_HALT: begin
                    halt_ack = 1'b1;
                    if (PCSrc_EX) begin
                        PC_write    = 1'b1;
                        IF_ID_write = 1'b1;
                        IF_ID_flush = 1'b1;
                        flush_inc   = 1'b1;
                    end else if (!halt_req) begin
                        state_d = ST_RUN;
                    end
                end
                default: begin
                    state_d = ST_BOOT;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= RESET_ST;
            boot_cnt_q  <= '0;
            drain_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            boot_cnt_q  <= boot_cnt_d;
            drain_cnt_q <= drain_cnt_d;
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (stall_inc),
        .q     (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (flush_inc),
        .q     (flush_cnt)
    );

endmodule
